// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per clock, unsigned or signed operands
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, product_q, product_d;
  logic               accept, last;
  always_comb begin
    accept    = start && (state_q == IDLE || state_q == DONE);
    last      = cnt_q == CW'(WIDTH - 1);
    state_d   = accept ? RUN :
                (state_q == RUN && last) ? FIX :
                state_q == FIX ? DONE :
                state_q == DONE ? IDLE : state_q;
    // operands are stored as magnitudes; the sign is reapplied once at FIX
    a_d       = accept ? ((is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand) : a_q;
    b_d       = accept ? ((is_signed && multiplier[WIDTH-1]) ? -multiplier : multiplier) : b_q;
    sign_d    = accept ? (is_signed && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1])) : sign_q;
    cnt_d     = accept ? '0 : state_q == RUN ? cnt_q + CW'(1) : cnt_q;
    acc_d     = accept ? '0 :
                (state_q == RUN && b_q[cnt_q]) ? acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q) : acc_q;
    product_d = state_q == FIX ? (sign_q ? -acc_q : acc_q) : product_q;
    busy      = state_q == RUN || state_q == FIX;
    done      = state_q == DONE;
    product   = product_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and exhaustive checks of seq_multiplier at WIDTH=4
module tb_seq_multiplier;
  logic       clk = 0, rst_n = 0, start = 0, is_signed = 0;
  logic [3:0] a = 0, b = 0;
  logic       busy, done;
  logic [7:0] product;
  int         n_tests = 0, n_fail = 0;
  int         lat, bc;

  seq_multiplier #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .multiplicand(a), .multiplier(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y, input logic s);
    int xi, yi, p;
    xi = (s && x[3]) ? int'(x) - 16 : int'(x);
    yi = (s && y[3]) ? int'(y) - 16 : int'(y);
    p  = xi * yi;
    return p[7:0];
  endfunction

  // returns at the negedge after the accept edge with start low again
  task automatic launch(input logic [3:0] x, input logic [3:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(output int l, output int bcnt);
    bcnt = busy ? 1 : 0;
    l = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        l = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic run_check(input string tag, input logic [3:0] x, input logic [3:0] y,
                           input logic s, input logic [7:0] exp);
    launch(x, y, s);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_prod"}, product, exp);
  endtask

  initial begin
    int d0, d1, cyc, seen;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    @(negedge clk) rst_n = 1;

    launch(4'hD, 4'hB, 0);
    wait_done(lat, bc);
    check("t1_lat", lat, 5);
    check("t1_busy_cycles", bc, 5);
    check("t1_busy_in_done", busy, 0);
    check("t1_prod", product, 8'h8F);
    @(posedge clk); #1;
    check("t1_done_pulse", done, 0);

    run_check("t2_m3x5", 4'hD, 4'h5, 1, 8'hF1);
    run_check("t2_m8xm8", 4'h8, 4'h8, 1, 8'h40);
    run_check("t2_7xm8", 4'h7, 4'h8, 1, 8'hC8);

    run_check("t3_15x15u", 4'hF, 4'hF, 0, 8'hE1);
    run_check("t3_0xFs", 4'h0, 4'hF, 1, 8'h00);
    run_check("t3_0xFu", 4'h0, 4'hF, 0, 8'h00);
    run_check("t3_Fx0s", 4'hF, 4'h0, 1, 8'h00);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) begin
        logic [7:0] v;
        v = 8'(i);
        launch(v[7:4], v[3:0], s[0]);
        wait_done(lat, bc);
        check($sformatf("sweep_s%0d_%h_%h", s, v[7:4], v[3:0]), product, ref_mul(v[7:4], v[3:0], s[0]));
      end

    launch(4'hD, 4'hB, 0);
    @(negedge clk);
    a = 4'h1; b = 4'h1; is_signed = 1; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(lat, bc);
    check("t4_ign_lat", lat, 3);
    check("t4_ign_prod", product, 8'h8F);
    repeat (3) @(posedge clk);
    #1;
    check("t4_ign_idle", busy, 0);
    check("t4_ign_hold", product, 8'h8F);

    @(negedge clk);
    a = 4'h2; b = 4'h3; is_signed = 0; start = 1;
    d0 = 0; d1 = 0; cyc = 0;
    repeat (14) begin
      @(posedge clk); #1;
      cyc++;
      if (done && d0 == 0) d0 = cyc;
      else if (done && d1 == 0) d1 = cyc;
    end
    @(negedge clk) start = 0;
    check("t4_b2b_first", d0, 6);
    check("t4_b2b_gap", d1 - d0, 6);
    wait_done(lat, bc);
    check("t4_b2b_prod", product, 8'h06);
    check("t4_b2b_end", lat != 99, 1);

    launch(4'h7, 4'h3, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_prod", product, 0);
    @(negedge clk) rst_n = 1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      seen |= int'(done);
    end
    check("t5_no_done", seen, 0);
    run_check("t5_after", 4'h7, 4'h3, 0, 8'h15);

    launch(4'h7, 4'h6, 0);
    @(negedge clk);
    a = 4'hF; b = 4'hF; is_signed = 1;
    wait_done(lat, bc);
    check("t6_lat", lat, 4);
    check("t6_prod", product, 8'h2A);
    repeat (3) @(posedge clk);
    #1;
    check("t6_hold", product, 8'h2A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
